pinmux_input_filter: RTL

PINMUX_INPUT_FILTER -- requirements
Module: pinmux_input_filter

---
 rtl/pinmux_filter_pkg.sv | 43 ++++
 rtl/pinmux_sync_cell.sv | 29 ++
 rtl/pinmux_input_filter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pinmux_filter_pkg.sv
// Shared types and constants for the pad input filter: debounce FSM states,
// tick-rate select encodings, prescaler masks and bypass bit positions.
package pinmux_filter_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } db_state_e;

  localparam logic [1:0] CLK_SEL_DIV1  = 2'b00;
  localparam logic [1:0] CLK_SEL_DIV4  = 2'b01;
  localparam logic [1:0] CLK_SEL_DIV16 = 2'b10;
  localparam logic [1:0] CLK_SEL_DIV64 = 2'b11;

  localparam int PRESC_WIDTH = 6;

  localparam logic [PRESC_WIDTH-1:0] PRESC_MASK_DIV1  = 6'h00;
  localparam logic [PRESC_WIDTH-1:0] PRESC_MASK_DIV4  = 6'h03;
  localparam logic [PRESC_WIDTH-1:0] PRESC_MASK_DIV16 = 6'h0F;
  localparam logic [PRESC_WIDTH-1:0] PRESC_MASK_DIV64 = 6'h3F;

  localparam int BYP_GLITCH   = 0;
  localparam int BYP_DEBOUNCE = 1;
  localparam int BYP_FULL     = 2;

  // A tick fires when every masked prescaler bit is set; an empty mask ticks
  // every cycle.
  function automatic logic [PRESC_WIDTH-1:0] presc_mask(input logic [1:0] sel);
    logic [PRESC_WIDTH-1:0] m;
    case (sel)
      CLK_SEL_DIV1:  m = PRESC_MASK_DIV1;
      CLK_SEL_DIV4:  m = PRESC_MASK_DIV4;
      CLK_SEL_DIV16: m = PRESC_MASK_DIV16;
      default:       m = PRESC_MASK_DIV64;
    endcase
    return m;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pinmux_sync_cell.sv
// Multi-flop synchronizer for a single asynchronous bit; STAGES flops deep,
// cleared by a synchronous active-high reset.
module pinmux_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign o_q = chain_q[STAGES-1];

endmodule

// File: rtl/pinmux_input_filter.sv
// Pad input conditioning: IE gate, synchronizer, 3-sample majority glitch
// filter, prescaled debounce qualifier and optional edge pulses.
// Edge detection is built only when PINMUX_IN_FILTER_EDGE_DET_EN is defined.
module pinmux_input_filter
  import pinmux_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pad_in,
  input  logic                 i_ie,
  input  logic [1:0]           i_clk_sel,
  input  logic [2:0]           i_bypass,
  input  logic [CNT_WIDTH-1:0] i_db_thresh,
  output logic                 o_sync,
  output logic                 o_filtered,
  output logic                 o_busy,
  output logic                 o_rise,
  output logic                 o_fall
);

  logic pad_gated;
  logic sync;

  assign pad_gated = i_pad_in & i_ie;

  pinmux_sync_cell #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (pad_gated),
    .o_q   (sync)
  );

  assign o_sync = sync;

  // Glitch stage: a level must be seen on two of the last three samples.
  logic h0_q, h0_d;
  logic h1_q, h1_d;
  logic g_q, g_d;

  always_comb begin
    h0_d = sync;
    h1_d = h0_q;
    if (i_bypass[BYP_GLITCH]) begin
      g_d = sync;
    end else begin
      g_d = majority3(sync, h0_q, h1_q);
    end
  end

  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] tick_mask;
  logic                   tick;

  always_comb begin
    presc_d   = presc_q + PRESC_WIDTH'(1);
    tick_mask = presc_mask(i_clk_sel);
    tick      = ((presc_q & tick_mask) == tick_mask);
  end

  // Debounce: the filtered level only follows g after g has disagreed with it
  // for i_db_thresh+1 ticks without interruption.
  db_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   filt_q, filt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    if (i_bypass[BYP_FULL]) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
      filt_d  = sync;
    end else if (i_bypass[BYP_DEBOUNCE]) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
      filt_d  = g_q;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (g_q != filt_q) begin
            state_d = ST_QUALIFY;
            cnt_d   = '0;
          end
        end
        ST_QUALIFY: begin
          if (g_q == filt_q) begin
            state_d = ST_STABLE;
          end else if (tick) begin
            if (cnt_q == i_db_thresh) begin
              filt_d  = g_q;
              state_d = ST_STABLE;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = ST_STABLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h0_q    <= 1'b0;
      h1_q    <= 1'b0;
      g_q     <= 1'b0;
      presc_q <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
    end else begin
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      g_q     <= g_d;
      presc_q <= presc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  assign o_filtered = filt_q;
  assign o_busy     = (state_q == ST_QUALIFY);

`ifdef PINMUX_IN_FILTER_EDGE_DET_EN
  // prev clears together with filt_q, so reset never produces a pulse.
  logic prev_q, prev_d;

  always_comb begin
    prev_d = filt_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign o_rise = filt_q & ~prev_q;
  assign o_fall = prev_q & ~filt_q;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule
